// File: rtl/fibo_controller_if.sv
// Bundle of the fibo_controller user handshake and the datapath control/status
// wires. The master side is the controller; the slave side is whoever drives
// start/n and hosts the register file + ALU (the datapath, or a bench model).
//
// Handshake: start is a level sampled only while the controller is idle
// (busy=0). When sampled high, n is latched and busy rises on the next cycle.
// done is a single-cycle pulse; result (and ovf, when built with
// FIBO_OVF_DETECT_EN) is valid in that cycle and holds until the next done.
// There is no backpressure and no queuing: start while busy is dropped.
interface fibo_controller_if #(
   parameter int SIZE = 4
);
   // user side
   logic            start;
   logic [SIZE-1:0] n;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] result;
`ifdef FIBO_OVF_DETECT_EN
   logic            ovf;
`endif

   // datapath side
   logic            zero_flag;
   logic [SIZE-1:0] data;
   logic [SIZE-3:0] wrt_addr;
   logic            wrt_en;
   logic            load_data;
   logic [SIZE-1:0] count;
   logic [SIZE-3:0] rd_addr1;
   logic [SIZE-3:0] rd_addr2;
   logic [SIZE-2:0] alu_opcode;

   // controller view
   modport master (
      input  start, n, zero_flag, data,
      output wrt_addr, wrt_en, load_data, count, rd_addr1, rd_addr2,
             alu_opcode, busy, done, result
`ifdef FIBO_OVF_DETECT_EN
             , ovf
`endif
   );

   // requester + datapath view
   modport slave (
      output start, n, zero_flag, data,
      input  wrt_addr, wrt_en, load_data, count, rd_addr1, rd_addr2,
             alu_opcode, busy, done, result
`ifdef FIBO_OVF_DETECT_EN
             , ovf
`endif
   );

endinterface

// File: rtl/fibo_controller.sv
// fibo_controller: sequences the Fibonacci datapath (4-entry register file,
// ALU, registered `data`) to compute F(n) mod 2^SIZE.
// Register roles: R0/R1 hold the Fibonacci pair, R2 is the loop counter,
// R3 holds the constant 1. The answer ends up in R[n%2].
// Optional build macro FIBO_OVF_DETECT_EN adds the `ovf` output, flagging that
// the returned F(n) wrapped modulo 2^SIZE.
// dbg_state exposes the FSM state encoding for observation.
module fibo_controller #(
   parameter int              SIZE   = 4,
   parameter logic [SIZE-2:0] OP_ADD = 3'b000,
   parameter logic [SIZE-2:0] OP_SUB = 3'b001
) (
   input  logic              clk,
   input  logic              rst,
   fibo_controller_if.master bus,
   output logic [3:0]        dbg_state
);

   localparam int AW = SIZE - 2;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LD_N    = 4'd1,
      LD_ONE  = 4'd2,
      LD_A    = 4'd3,
      LD_B    = 4'd4,
      DEC     = 4'd5,
      UPD_CNT = 4'd6,
      UPD_FIB = 4'd7,
      READ    = 4'd8,
      CAP     = 4'd9
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] n_q, n_d;
   logic            parity_q, parity_d;
   logic            last_q, last_d;
   logic            done_q, done_d;
   logic [SIZE-1:0] result_q, result_d;

`ifdef FIBO_OVF_DETECT_EN
   logic [SIZE-1:0] prev_q, prev_d;
   logic            ovf_q, ovf_d;
   logic            ovf_out_q, ovf_out_d;
`endif

   // Moore datapath controls
   logic            wrt_en;
   logic            load_data;
   logic [AW-1:0]   wrt_addr;
   logic [SIZE-1:0] count;
   logic [AW-1:0]   rd_addr1;
   logic [AW-1:0]   rd_addr2;
   logic [SIZE-2:0] alu_opcode;

   // State register and all controller flops; async reset returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         n_q       <= '0;
         parity_q  <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
`ifdef FIBO_OVF_DETECT_EN
         prev_q    <= '0;
         ovf_q     <= 1'b0;
         ovf_out_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         parity_q  <= parity_d;
         last_q    <= last_d;
         done_q    <= done_d;
         result_q  <= result_d;
`ifdef FIBO_OVF_DETECT_EN
         prev_q    <= prev_d;
         ovf_q     <= ovf_d;
         ovf_out_q <= ovf_out_d;
`endif
      end
   end

   // Next-state and Moore decode of the datapath controls from the current state.
   always_comb begin
      state_d    = state_q;
      wrt_en     = 1'b0;
      load_data  = 1'b0;
      count      = '0;
      wrt_addr   = '0;
      rd_addr1   = '0;
      rd_addr2   = '0;
      alu_opcode = OP_ADD;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = LD_N;
         end
         // R2 <= n (loop counter)
         LD_N: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = AW'(2);
            count     = n_q;
            state_d   = LD_ONE;
         end
         // R3 <= 1 (decrement constant)
         LD_ONE: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = AW'(3);
            count     = SIZE'(1);
            state_d   = LD_A;
         end
         // R0 <= F(0)
         LD_A: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = AW'(0);
            count     = '0;
            state_d   = LD_B;
         end
         // R1 <= F(1); n=0 skips the loop entirely
         LD_B: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = AW'(1);
            count     = SIZE'(1);
            state_d   = (n_q == '0) ? READ : DEC;
         end
         // ALU computes R2-R3; zero_flag says this is the final iteration
         DEC: begin
            rd_addr1   = AW'(2);
            rd_addr2   = AW'(3);
            alu_opcode = OP_SUB;
            state_d    = UPD_CNT;
         end
         // write back decremented count while the ALU forms R0+R1
         UPD_CNT: begin
            wrt_en     = 1'b1;
            wrt_addr   = AW'(2);
            rd_addr1   = AW'(0);
            rd_addr2   = AW'(1);
            alu_opcode = OP_ADD;
            state_d    = UPD_FIB;
         end
         // overwrite the older half of the pair with the new sum
         UPD_FIB: begin
            wrt_en   = 1'b1;
            wrt_addr = AW'(parity_q);
            state_d  = last_q ? READ : DEC;
         end
         // R2 is zero here, so the ALU passes R[n%2] through
         READ: begin
            rd_addr1   = AW'(n_q[0]);
            rd_addr2   = AW'(2);
            alu_opcode = OP_ADD;
            state_d    = CAP;
         end
         CAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values of the operand latch, loop bookkeeping and the result registers.
   always_comb begin
      n_d      = n_q;
      parity_d = parity_q;
      last_d   = last_q;
      done_d   = 1'b0;
      result_d = result_q;
`ifdef FIBO_OVF_DETECT_EN
      prev_d    = prev_q;
      ovf_d     = ovf_q;
      ovf_out_d = ovf_out_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               n_d      = bus.n;
               parity_d = 1'b0;
`ifdef FIBO_OVF_DETECT_EN
               ovf_d    = 1'b0;
`endif
            end
         end
`ifdef FIBO_OVF_DETECT_EN
         LD_B: begin
            prev_d = SIZE'(1);
         end
`endif
         DEC: begin
            last_d = bus.zero_flag;
         end
         UPD_FIB: begin
            parity_d = ~parity_q;
`ifdef FIBO_OVF_DETECT_EN
            // The final iteration produces F(n+1), which is never returned, so
            // it must not raise the flag; a wrapped sum is always smaller than
            // its predecessor, which makes the compare exact.
            if (!last_q && (bus.data < prev_q)) ovf_d = 1'b1;
            prev_d = bus.data;
`endif
         end
         CAP: begin
            result_d = bus.data;
            done_d   = 1'b1;
`ifdef FIBO_OVF_DETECT_EN
            ovf_out_d = ovf_q;
`endif
         end
         default: begin
         end
      endcase
   end

   assign bus.wrt_en     = wrt_en;
   assign bus.load_data  = load_data;
   assign bus.wrt_addr   = wrt_addr;
   assign bus.count      = count;
   assign bus.rd_addr1   = rd_addr1;
   assign bus.rd_addr2   = rd_addr2;
   assign bus.alu_opcode = alu_opcode;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.result     = result_q;
`ifdef FIBO_OVF_DETECT_EN
   assign bus.ovf        = ovf_out_q;
`endif
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_fibo_controller.sv
// Bench for fibo_controller: hosts a behavioural register file + ALU model as
// the datapath, drives directed runs, and checks results through an expected
// queue filled at start and drained at done.
// Build with FIBO_OVF_DETECT_EN to also check the ovf output.
module tb_fibo_controller;

   localparam int SIZE = 4;
   localparam int W    = SIZE + 1; // {ovf, result}

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] dbg_state;

   int tests_run  = 0;
   int fail_count = 0;

   logic [W-1:0] exp_q[$];
   logic [5:0]   wlog[$];  // {addr, value} of every register-file write
   int           dec_count = 0;

   fibo_controller_if #(.SIZE(SIZE)) bus ();

   fibo_controller #(.SIZE(SIZE)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- datapath model ----------------
   logic [SIZE-1:0] rf [4] = '{default: '0};
   logic [SIZE-1:0] dp_data = '0;
   logic [SIZE-1:0] alu_y;

   always_comb begin
      alu_y = '0;
      if (bus.alu_opcode == 3'b001) alu_y = rf[bus.rd_addr1] - rf[bus.rd_addr2];
      else                          alu_y = rf[bus.rd_addr1] + rf[bus.rd_addr2];
   end

   assign bus.zero_flag = (alu_y == '0);
   assign bus.data      = dp_data;

   always @(posedge clk) begin
      dp_data <= alu_y;
      if (bus.wrt_en) begin
         rf[bus.wrt_addr] <= bus.load_data ? bus.count : dp_data;
         wlog.push_back({bus.wrt_addr, (bus.load_data ? bus.count : dp_data)});
      end
      if (dbg_state == 4'd5) dec_count <= dec_count + 1;
   end

   // ---------------- reference ----------------
   function automatic longint fib_full(input int nv);
      longint a = 0;
      longint b = 1;
      longint t;
      for (int i = 0; i < nv; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         fail_count++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // ---------------- drivers ----------------
   // Called just after a negedge; returns at the negedge after the accepting edge.
   task automatic start_run(input int nv);
      longint f;
      f = fib_full(nv);
      exp_q.push_back({(f > 64'(2**SIZE - 1)), SIZE'(f % (2**SIZE))});
      bus.start = 1'b1;
      bus.n     = SIZE'(nv);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Waits for done (bounded), optionally pulsing start at cycles pa/pb, then
   // pops the scoreboard and compares. Returns at the negedge where done is high.
   task automatic wait_done(input string tag, input int nv, input int pa, input int pb);
      int cycles;
      int busy_cycles;
      logic [W-1:0] e;
      cycles      = 0;
      busy_cycles = 0;
      while (!bus.done && cycles < 200) begin
         if (bus.busy) busy_cycles++;
         if (cycles == pa || cycles == pb) begin
            bus.start = 1'b1;
            bus.n     = 4'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, cycles, 6 + 3 * nv);
      check({tag, "_busy_cycles"}, busy_cycles, 6 + 3 * nv);
      check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_result"}, bus.result, e[SIZE-1:0]);
`ifdef FIBO_OVF_DETECT_EN
         check({tag, "_ovf"}, bus.ovf, e[SIZE]);
`endif
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0] exp_w [6];
      int         wbase;
      int         dbase;
      int         guard;
      exp_w = '{{2'd2, 4'd1}, {2'd3, 4'd1}, {2'd0, 4'd0},
                {2'd1, 4'd1}, {2'd2, 4'd0}, {2'd0, 4'd1}};

      bus.start = 1'b0;
      bus.n     = '0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);
      check("rst_wrt_en", bus.wrt_en, 0);
      check("rst_state", dbg_state, 0);
`ifdef FIBO_OVF_DETECT_EN
      check("rst_ovf", bus.ovf, 0);
`endif

      // n=0: no loop iterations
      dbase = dec_count;
      wbase = wlog.size();
      start_run(0);
      wait_done("n0", 0, -1, -1);
      check("n0_no_dec", dec_count - dbase, 0);
      check("n0_writes", wlog.size() - wbase, 4);
      @(negedge clk);
      check("n0_done_pulse", bus.done, 0);

      // n=1: full write trace
      wbase = wlog.size();
      start_run(1);
      wait_done("n1", 1, -1, -1);
      check("n1_write_count", wlog.size() - wbase, 6);
      for (int i = 0; i < 6; i++) begin
         if (wbase + i < wlog.size()) check($sformatf("n1_write%0d", i), wlog[wbase + i], exp_w[i]);
      end
      @(negedge clk);

      // larger indices, including wrap
      start_run(7);
      wait_done("n7", 7, -1, -1);
      @(negedge clk);
      check("n7_result_hold", bus.result, 13);
      start_run(10);
      wait_done("n10", 10, -1, -1);
      @(negedge clk);
      start_run(5);
      wait_done("n5", 5, -1, -1);
      @(negedge clk);
      start_run(15);
      wait_done("n15", 15, -1, -1);
      @(negedge clk);

      // start while busy is ignored; start in the done cycle is accepted
      start_run(4);
      wait_done("n4_ignore", 4, 3, 10);
      start_run(2);
      wait_done("n2_back2back", 2, -1, -1);
      @(negedge clk);

      // random indices
      for (int k = 0; k < 4; k++) begin
         int nv;
         nv = $urandom_range(0, 15);
         start_run(nv);
         wait_done($sformatf("rand%0d", k), nv, -1, -1);
         @(negedge clk);
      end

      // async reset in UPD_CNT of an n=6 run
      start_run(6);
      guard = 0;
      while (dbg_state != 4'd6 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("rst_mid_reached_upd_cnt", dbg_state, 6);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_wrt_en", bus.wrt_en, 0);
      check("rst_mid_done", bus.done, 0);
      check("rst_mid_result", bus.result, 0);
      check("rst_mid_state", dbg_state, 0);
      void'(exp_q.pop_back());  // aborted run produces no result
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_run(6);
      wait_done("n6_after_rst", 6, -1, -1);
      @(negedge clk);

      check("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
